// File: rtl/gray_ptr_receiver.sv
// Receive side of a Gray-coded pointer crossing: synchronizes gray_in into clk, converts
// it to binary and flags illegal multi-bit steps between successive samples.
module gray_ptr_receiver #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             changed,
    output logic             step_err,
    output logic             err_sticky
);

    localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);
    localparam logic [CntW-1:0] CntMax = CntW'(SYNC_STAGES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] g_sync;
    logic [WIDTH-1:0] g_prev_q, g_prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] diff;
    logic [CntW-1:0]  warm_q, warm_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             step_err_q, step_err_d;
    logic             sticky_q, sticky_d;

    assign g_sync = sync_q[SYNC_STAGES-1];
    assign diff   = g_sync ^ g_prev_q;

    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above its position.
    always_comb begin
        bin_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_d[i] = ^(g_sync >> i);
        end
    end

    always_comb begin
        g_prev_d   = g_sync;
        warm_d     = (warm_q == CntMax) ? warm_q : warm_q + CntW'(1);
        valid_d    = valid_q || (warm_q >= CntLast);
        // Pre-edge valid gates the checks so the first real sample never compares to reset state.
        changed_d  = valid_q && (diff != '0);
        step_err_d = valid_q && ((diff & (diff - WIDTH'(1))) != '0);
        if (step_err_d) begin
            sticky_d = 1'b1;
        end else if (clr_err) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            g_prev_q   <= '0;
            bin_q      <= '0;
            warm_q     <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            step_err_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            g_prev_q   <= g_prev_d;
            bin_q      <= bin_d;
            warm_q     <= warm_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            step_err_q <= step_err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bin_out    = bin_q;
    assign bin_valid  = valid_q;
    assign changed    = changed_q;
    assign step_err   = step_err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_ptr_receiver.sv
// Bench for gray_ptr_receiver: directed scenarios plus a random Gray walk, all checked
// against a history-based model of what each output should show after every edge.
module tb_gray_ptr_receiver;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] bin_out;
    logic         bin_valid, changed, step_err, err_sticky;

    gray_ptr_receiver #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .changed   (changed),
        .step_err  (step_err),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: gray_in values seen at each edge since reset release.
    int unsigned hist[$];
    int unsigned exp_bin;
    bit          exp_valid, exp_chg, exp_err, exp_sticky;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned g2b(input int unsigned g);
        for (int unsigned b = 0; b < (1 << W); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [W-1:0] b2g(input int unsigned b);
        int unsigned m;
        m = b % (1 << W);
        return W'(m ^ (m >> 1));
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_bin    = 0;
        exp_valid  = 0;
        exp_chg    = 0;
        exp_err    = 0;
        exp_sticky = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".bin_out"}, 32'(bin_out), exp_bin);
        check_eq({tag, ".bin_valid"}, 32'(bin_valid), 32'(exp_valid));
        check_eq({tag, ".changed"}, 32'(changed), 32'(exp_chg));
        check_eq({tag, ".step_err"}, 32'(step_err), 32'(exp_err));
        check_eq({tag, ".err_sticky"}, 32'(err_sticky), 32'(exp_sticky));
    endtask

    // One clock edge: update the model from the inputs seen at the edge, then check.
    task automatic tick(input string tag);
        int n;
        int unsigned cur, prv;
        @(posedge clk);
        hist.push_back(32'(gray_in));
        n         = hist.size();
        exp_bin   = (n > S) ? g2b(hist[n-1-S]) : 0;
        exp_valid = (n >= S + 1);
        exp_chg   = 0;
        exp_err   = 0;
        if (n >= S + 2) begin
            cur     = hist[n-1-S];
            prv     = hist[n-2-S];
            exp_chg = (cur != prv);
            exp_err = ($countones(cur ^ prv) > 1);
        end
        if (exp_err) exp_sticky = 1;
        else if (clr_err) exp_sticky = 0;
        #1;
        check_all(tag);
    endtask

    task automatic hold(input logic [W-1:0] g, input int cycles, input string tag);
        gray_in = g;
        for (int i = 0; i < cycles; i++) tick(tag);
    endtask

    int unsigned pos;
    int unsigned r;
    bit          hit;

    initial begin
        model_reset();
        // Reset and latency with a constant nonzero input.
        gray_in = 4'b0110;
        #2;
        check_all("in_reset");
        #10;
        rst_n = 1'b1;
        tick("warm1");
        tick("warm2");
        tick("warm3");
        check_eq("latency_bin", 32'(bin_out), 32'd4);
        check_eq("latency_valid", 32'(bin_valid), 32'd1);
        hold(4'b0110, 2, "hold");

        // Full up count through the Gray sequence.
        for (int v = 0; v < 16; v++) hold(b2g(v), 3, "count_up");
        // Wrap 15 -> 0, then down-wrap 0 -> 15.
        hold(4'b0000, 3, "wrap_up");
        check_eq("wrap_up_bin", 32'(bin_out), 32'd0);
        hold(4'b1000, 3, "wrap_dn");
        check_eq("wrap_dn_bin", 32'(bin_out), 32'd15);
        hold(4'b0000, 4, "wrap_back");

        // Illegal two-bit jump, then clear.
        hold(4'b0011, 3, "jump");
        check_eq("jump_bin", 32'(bin_out), 32'd2);
        check_eq("jump_err", 32'(step_err), 32'd1);
        hold(4'b0011, 2, "jump_hold");
        check_eq("sticky_held", 32'(err_sticky), 32'd1);
        clr_err = 1'b1;
        tick("clr");
        clr_err = 1'b0;
        check_eq("sticky_clr", 32'(err_sticky), 32'd0);

        // Clear colliding with a two-bit step: set must win.
        hold(4'b0001, 4, "coll_pre");
        gray_in = 4'b0111;
        for (int i = 0; i < S; i++) tick("coll_wait");
        clr_err = 1'b1;
        tick("coll");
        clr_err = 1'b0;
        check_eq("coll_sticky", 32'(err_sticky), 32'd1);
        clr_err = 1'b1;
        tick("coll_clr");
        clr_err = 1'b0;

        // Count until bin_out shows 9, then reset asynchronously mid-cycle.
        hit = 0;
        pos = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            gray_in = b2g(pos);
            tick("to_nine");
            if (exp_bin == 9) hit = 1;
            else pos++;
        end
        check_eq("reached_nine", 32'(hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < S + 3; i++) tick("rewarm");

        // Random walk of legal steps with occasional illegal jumps and random clears.
        pos = 0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 15);
            if (r < 6) pos = pos + 1;
            else if (r < 11) pos = pos + 15;
            else if (r == 15) pos = $urandom_range(0, 15);
            gray_in = b2g(pos);
            clr_err = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        clr_err = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_ptr_receiver.md
Name: gray_ptr_receiver

Overview:
- Receive end of the Gray-coded pointer path. Takes a Gray-coded count launched from another clock domain and synchronizes it into clk.
- Converts the synchronized value back to binary and flags any illegal multi-bit step between successive samples.
- Sits on the read or write side of async FIFOs and cross-domain counters, opposite the binary-to-Gray encoder.

Parameters:
- WIDTH, 4, pointer width in bits; legal range is 2 or more.
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on gray_in; legal range is 2 or more.

Ports:
- clk  input  1  receive-domain clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gray_in  input  WIDTH  Gray-coded pointer from the foreign domain; asynchronous to clk.
- clr_err  input  1  synchronous clear of err_sticky.
- bin_out  output  WIDTH  binary equivalent of the synchronized Gray value; registered.
- bin_valid  output  1  high once the pipeline holds a real sample; stays high until reset.
- changed  output  1  one-cycle pulse when the synchronized value differs from the previous sample.
- step_err  output  1  one-cycle pulse when successive samples differ in more than one bit.
- err_sticky  output  1  set by step_err, held until clr_err.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0):
  - Asserts immediately, independent of clk.
  - Clears all synchronizer stages, g_prev, bin_out, bin_valid, changed, step_err, err_sticky and the warm-up counter to 0.
  - Deassertion is assumed already synchronized to clk upstream.
- Synchronizer:
  - sync[0] <= gray_in; sync[i] <= sync[i-1].
  - g_sync = sync[SYNC_STAGES-1].
  - No logic between stages.
- Conversion: combinational on g_sync.
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] ^ g[i], for i from WIDTH-2 down to 0.
  - Registered into bin_out every edge.
- Latency:
  - A gray_in value stable before edge k appears on bin_out after edge k+SYNC_STAGES.
  - That is SYNC_STAGES+1 cycles.
- Warm-up:
  - Count edges after reset release, saturating at SYNC_STAGES+1.
  - bin_valid is registered and becomes 1 at edge SYNC_STAGES+1, i.e. with the first meaningful bin_out.
- History: g_prev <= g_sync on every edge.
- Step check (all three outputs registered at the same edge as bin_out):
  - d = g_sync ^ g_prev.
  - changed <= bin_valid && (d != 0).
  - step_err <= bin_valid && (popcount(d) > 1).
  - bin_valid here is the pre-edge value, so the first sample after reset never flags.
- Single-bit steps are legal in either direction (+1 or -1). A zero-bit step (hold) is legal and gives changed=0.
- Wrap-around:
  - Gray 100..0 to 000..0 is a single-bit step: changed=1, step_err=0, bin_out goes from 2^WIDTH-1 to 0.
  - No arithmetic overflow handling is needed.
- err_sticky:
  - Set on the edge after step_err would be computed 1, i.e. it uses the same condition as step_err and is registered together with it.
  - Cleared when clr_err=1 at an edge.
  - Simultaneous set and clr_err: set wins, so err_sticky=1.
- Reset mid-operation: all outputs return to 0 asynchronously. The warm-up repeats in full after release; no stale g_prev comparison is made.
- No backpressure: the block is free-running every cycle.

Test Plan:
- Reset and latency (WIDTH=4, SYNC_STAGES=2): hold gray_in=0110, release rst_n.
  - bin_valid=0 and bin_out=0 for edges 1-2.
  - At edge 3: bin_out=0100, bin_valid=1, changed=0, step_err=0.
- Full count: drive the Gray sequence 0000,0001,0011,...,1000 (one value per 3 cycles).
  - bin_out steps 0..15 in order, each delayed 3 cycles.
  - Each change gives a single changed pulse; step_err never asserts.
- Wrap: gray_in goes from 1000 to 0000.
  - bin_out goes from 15 to 0, changed=1, step_err=0. Repeat the same check downward, 0000 to 1000.
- Illegal jump: gray_in goes from 0000 to 0011 (two bits).
  - 3 cycles later: bin_out=0010, changed=1, step_err=1 for one cycle, err_sticky=1 and held.
  - Pulse clr_err: err_sticky=0.
- Clear collision: raise clr_err on the same edge a 0001 to 0111 step registers.
  - err_sticky stays 1.
- Mid-operation reset: while counting at bin_out=9, pulse rst_n low asynchronously (not clk-aligned).
  - All outputs are 0 immediately.
  - After release, bin_valid reasserts only after SYNC_STAGES+1 edges, with no step_err even though gray_in is nonzero.
